// File: rtl/jpeg_byte_stuffer.sv
// Serialises 32-bit words MSB-first into bytes, inserting 0x00 after each 0xFF and appending EOI on the last word.
// Latency: first byte is valid the cycle after the word is accepted. Backpressure: outputs hold while byte_out_ready is low.
// word_in_ready may be high combinationally on the final byte of a word, giving back-to-back streaming.
module jpeg_byte_stuffer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        word_in_valid,
    input  logic [31:0] word_in,
    input  logic [1:0]  word_in_nbytes,
    input  logic        word_in_last,
    output logic        word_in_ready,
    output logic        byte_out_valid,
    output logic [7:0]  byte_out,
    input  logic        byte_out_ready,
    output logic [31:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_STUFF,
        S_EOI_FF,
        S_EOI_D9
    } state_t;

    state_t      state;
    logic [31:0] word_q;
    logic [2:0]  n_q;
    logic        last_q;
    logic [1:0]  idx_q;

    logic        xfer;
    logic        accept;
    logic        more;
    logic [1:0]  idx_nxt;
    logic [2:0]  n_in;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign idx_nxt        = idx_q + 2'd1;
    assign more           = ({1'b0, idx_q} + 3'd1) < n_q;
    assign n_in           = (word_in_nbytes == 2'd0) ? 3'd4 : {1'b0, word_in_nbytes};
    assign byte_out_valid = (state != S_IDLE);
    assign xfer           = byte_out_valid && byte_out_ready;

    // Accepting in EMIT only happens on the last byte of a non-final word, so it implies a transfer.
    assign word_in_ready  = (state == S_IDLE) ||
                            ((state == S_EMIT) && !more && (byte_out != 8'hFF) &&
                             !last_q && byte_out_ready);
    assign accept         = word_in_valid && word_in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            word_q     <= '0;
            n_q        <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            byte_out   <= 8'h00;
            byte_count <= '0;
        end else begin
            if (xfer) begin
                byte_count <= byte_count + 32'd1;
            end
            if (accept) begin
                word_q   <= word_in;
                n_q      <= n_in;
                last_q   <= word_in_last;
                idx_q    <= 2'd0;
                byte_out <= word_in[31:24];
                state    <= S_EMIT;
            end else if (xfer) begin
                case (state)
                    S_EMIT: begin
                        if (byte_out == 8'hFF) begin
                            byte_out <= 8'h00;
                            state    <= S_STUFF;
                        end else if (more) begin
                            idx_q    <= idx_nxt;
                            byte_out <= byte_sel(word_q, idx_nxt);
                        end else if (last_q) begin
                            byte_out <= 8'hFF;
                            state    <= S_EOI_FF;
                        end else begin
                            byte_out <= 8'h00;
                            state    <= S_IDLE;
                        end
                    end
                    S_STUFF: begin
                        if (more) begin
                            idx_q    <= idx_nxt;
                            byte_out <= byte_sel(word_q, idx_nxt);
                            state    <= S_EMIT;
                        end else if (last_q) begin
                            byte_out <= 8'hFF;
                            state    <= S_EOI_FF;
                        end else begin
                            byte_out <= 8'h00;
                            state    <= S_IDLE;
                        end
                    end
                    S_EOI_FF: begin
                        byte_out <= 8'hD9;
                        state    <= S_EOI_D9;
                    end
                    S_EOI_D9: begin
                        byte_out <= 8'h00;
                        state    <= S_IDLE;
                    end
                    default: begin
                        byte_out <= 8'h00;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Bench for jpeg_byte_stuffer: directed scenarios plus randomized words against a byte-list reference model.
module tb_jpeg_byte_stuffer;

    logic        clock;
    logic        reset_n;
    logic        word_in_valid;
    logic [31:0] word_in;
    logic [1:0]  word_in_nbytes;
    logic        word_in_last;
    logic        word_in_ready;
    logic        byte_out_valid;
    logic [7:0]  byte_out;
    logic        byte_out_ready;
    logic [31:0] byte_count;

    typedef struct {
        logic [31:0] w;
        logic [1:0]  nb;
        logic        last;
    } word_t;

    int          vectors;
    int          miscompares;
    logic        acc;
    logic        xfer;
    logic [7:0]  xbyte;
    logic        timed_out;
    int          stall_viol;
    word_t       wq[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          byte_cyc[$];
    logic        rdy_q[$];

    jpeg_byte_stuffer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .word_in_valid  (word_in_valid),
        .word_in        (word_in),
        .word_in_nbytes (word_in_nbytes),
        .word_in_last   (word_in_last),
        .word_in_ready  (word_in_ready),
        .byte_out_valid (byte_out_valid),
        .byte_out       (byte_out),
        .byte_out_ready (byte_out_ready),
        .byte_count     (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the byte list a word should produce, from the JPEG stuffing rules.
    function automatic void model_word(input word_t x);
        int n;
        logic [7:0] b;
        n = (x.nb == 2'd0) ? 4 : int'(x.nb);
        for (int i = 0; i < n; i++) begin
            b = x.w[31 - 8*i -: 8];
            exp_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
        if (x.last) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hD9);
        end
    endfunction

    // Drive one cycle's inputs at the falling edge, then observe the handshakes that the next rising edge completes.
    task automatic step(input logic wv, input logic [31:0] w, input logic [1:0] nb,
                        input logic l, input logic bor);
        @(negedge clock);
        word_in_valid  = wv;
        word_in        = w;
        word_in_nbytes = nb;
        word_in_last   = l;
        byte_out_ready = bor;
        #1;
        acc   = wv && word_in_ready;
        xfer  = byte_out_valid && bor;
        xbyte = byte_out;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        word_in_valid  = 1'b0;
        word_in        = '0;
        word_in_nbytes = '0;
        word_in_last   = 1'b0;
        byte_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Feeds wq, collecting transferred bytes until exp_q's length is reached or the budget expires.
    task automatic run(input int rdy_pct, input int vld_pct, input int max_cyc);
        int wi;
        logic wv, bor, prev_stall;
        logic [7:0] prev_b;
        got_q.delete(); byte_cyc.delete(); rdy_q.delete();
        timed_out = 1'b0; stall_viol = 0; wi = 0; prev_stall = 1'b0; prev_b = '0;
        for (int c = 0; ; c++) begin
            if (wi == wq.size() && got_q.size() >= exp_q.size()) break;
            if (c >= max_cyc) begin timed_out = 1'b1; break; end
            wv  = (wi < wq.size()) && ($urandom_range(99) < vld_pct);
            bor = $urandom_range(99) < rdy_pct;
            if (wv) step(1'b1, wq[wi].w, wq[wi].nb, wq[wi].last, bor);
            else    step(1'b0, 32'h0, 2'd0, 1'b0, bor);
            if (prev_stall && (!byte_out_valid || byte_out !== prev_b)) stall_viol++;
            prev_stall = byte_out_valid && !bor;
            prev_b     = byte_out;
            if (acc) wi++;
            if (xfer) begin
                got_q.push_back(xbyte);
                byte_cyc.push_back(c);
                rdy_q.push_back(word_in_ready);
            end
        end
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        word_in_valid = 1'b0; word_in = '0; word_in_nbytes = '0; word_in_last = 1'b0;
        byte_out_ready = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (byte_out_valid !== 1'b0 || byte_out !== 8'h00 || byte_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b byte=%h count=%0d, required 0/00/0", byte_out_valid, byte_out, byte_count);
        end
        reset_n = 1'b1;
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        vectors++;
        if (word_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: word_in_ready=%b, required 1", word_in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        wq = '{'{w: 32'h12345678, nb: 2'd0, last: 1'b0}};
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run(100, 100, 50);
        vectors++;
        if (timed_out || got_q.size() != 4) begin
            miscompares++;
            $display("FAIL single_len: got %0d bytes timeout=%b, required 4", got_q.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL single_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
                end
            end
            vectors++;
            if (byte_cyc[3] - byte_cyc[0] != 3) begin
                miscompares++;
                $display("FAIL single_spacing: span %0d cycles, required 3", byte_cyc[3] - byte_cyc[0]);
            end
        end
        vectors++;
        if (byte_count !== 32'd4 || byte_out_valid !== 1'b0 || word_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_end: count=%0d valid=%b ready=%b, required 4/0/1", byte_count, byte_out_valid, word_in_ready);
        end
    endtask

    task automatic test_stuff();
        do_reset();
        wq = '{'{w: 32'hFF00FFAB, nb: 2'd0, last: 1'b0}};
        exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
        run(100, 100, 50);
        vectors++;
        if (timed_out || got_q != exp_q || byte_count !== 32'd6) begin
            miscompares++;
            $display("FAIL stuff_seq: got %p count=%0d, required %p count=6", got_q, byte_count, exp_q);
        end
    endtask

    task automatic test_eoi_partial();
        do_reset();
        wq = '{'{w: 32'hAABBFFDD, nb: 2'd2, last: 1'b1}};
        exp_q = '{8'hAA, 8'hBB, 8'hFF, 8'hD9};
        run(100, 100, 50);
        vectors++;
        if (timed_out || got_q != exp_q || byte_count !== 32'd4 || byte_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL eoi_seq: got %p count=%0d valid=%b, required %p count=4 valid=0", got_q, byte_count, byte_out_valid, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wq = '{'{w: 32'h01020304, nb: 2'd0, last: 1'b0}, '{w: 32'h05060708, nb: 2'd0, last: 1'b0}};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run(100, 100, 50);
        vectors++;
        if (timed_out || got_q != exp_q) begin
            miscompares++;
            $display("FAIL b2b_seq: got %p, required %p", got_q, exp_q);
        end else begin
            vectors++;
            if (byte_cyc[7] - byte_cyc[0] != 7) begin
                miscompares++;
                $display("FAIL b2b_spacing: span %0d cycles, required 7", byte_cyc[7] - byte_cyc[0]);
            end
            vectors++;
            if (rdy_q[3] !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready: word_in_ready=%b during byte 04, required 1", rdy_q[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] tail[3];
        tail = '{8'h22, 8'h33, 8'h44};
        do_reset();
        step(1'b1, 32'h11223344, 2'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        vectors++;
        if (!xfer || xbyte !== 8'h11) begin
            miscompares++;
            $display("FAIL bp_first: xfer=%b byte=%h, required 1/11", xfer, xbyte);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
            vectors++;
            if (byte_out_valid !== 1'b1 || byte_out !== 8'h22) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid=%b byte=%h, required 1/22", i, byte_out_valid, byte_out);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
            vectors++;
            if (!xfer || xbyte !== tail[i]) begin
                miscompares++;
                $display("FAIL bp_resume%0d: xfer=%b byte=%h, required 1/%h", i, xfer, xbyte, tail[i]);
            end
        end
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        vectors++;
        if (byte_count !== 32'd4 || byte_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_count: count=%0d valid=%b, required 4/0", byte_count, byte_out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        step(1'b1, 32'h12345678, 2'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        vectors++;
        if (byte_out !== 8'h56 || byte_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: byte=%h valid=%b, required 56/1", byte_out, byte_out_valid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (byte_out_valid !== 1'b0 || byte_count !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_async: valid=%b count=%0d, required 0/0", byte_out_valid, byte_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        wq = '{'{w: 32'h9A000000, nb: 2'd1, last: 1'b0}};
        exp_q = '{8'h9A};
        run(100, 100, 50);
        vectors++;
        if (timed_out || got_q != exp_q || byte_count !== 32'd1) begin
            miscompares++;
            $display("FAIL midrst_after: got %p count=%0d, required %p count=1", got_q, byte_count, exp_q);
        end
    endtask

    task automatic test_random();
        word_t x;
        int errs;
        do_reset();
        wq.delete(); exp_q.delete();
        for (int i = 0; i < 60; i++) begin
            x.w = '0;
            for (int j = 0; j < 4; j++) begin
                x.w = (x.w << 8) | (($urandom_range(3) == 0) ? 32'hFF : 32'($urandom_range(255)));
            end
            x.nb   = 2'($urandom_range(3));
            x.last = ($urandom_range(4) == 0);
            wq.push_back(x);
            model_word(x);
        end
        run(70, 75, 5000);
        vectors++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_len: got %0d bytes timeout=%b, required %0d", got_q.size(), timed_out, exp_q.size());
        end
        errs = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                errs++;
                if (errs <= 8) $display("FAIL rand_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (stall_viol != 0) begin
            miscompares++;
            $display("FAIL rand_stall: %0d unstable stalled cycles, required 0", stall_viol);
        end
        vectors++;
        if (byte_count !== 32'(exp_q.size())) begin
            miscompares++;
            $display("FAIL rand_count: count=%0d, required %0d", byte_count, exp_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_stuff();
        test_eoi_partial();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
